// File: rtl/plot_capture.sv
// Pixel-plot capture: validates drawer pixels, queues them and drains them to the framebuffer write port.
// Per-frame stats are reported after each flush. Defining PLOT_CAPTURE_BBOX_EN adds bounding-box tracking.
module plot_capture #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned X_MAX      = 159,
  parameter int unsigned Y_MAX      = 119,
  parameter int unsigned FB_WIDTH   = 160
) (
  input  logic        iClock,
  input  logic        iResetn,
  input  logic [7:0]  iX,
  input  logic [6:0]  iY,
  input  logic [5:0]  iColour,
  input  logic        iPlot,
  input  logic        iFrameDone,
  output logic        oReady,
  output logic [14:0] oAddr,
  output logic [5:0]  oData,
  output logic        oWe,
  input  logic        iMemReady,
  output logic        oFrameValid,
  output logic [15:0] oPixCount,
  output logic [7:0]  oDropCount,
  output logic [7:0]  oMinX,
  output logic [7:0]  oMaxX,
  output logic [6:0]  oMinY,
  output logic [6:0]  oMaxY
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  XMAX     = 8'(X_MAX);
  localparam logic [6:0]  YMAX     = 7'(Y_MAX);
  localparam logic [14:0] FBW      = 15'(FB_WIDTH);

  typedef enum logic [1:0] {RUN, FLUSH, REPORT} state_t;
  state_t state_q, state_d;

  logic [14:0]   addr_mem [FIFO_DEPTH];
  logic [5:0]    col_mem  [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   pix_q, pix_d, stat_pix_q;
  logic [7:0]    drop_q, drop_d, stat_drop_q;
  logic          in_range, push, pop, drop;
  logic [14:0]   addr_in;

  assign in_range = (iX <= XMAX) && (iY <= YMAX);
  assign oReady   = (state_q == RUN) && (cnt_q != FULL_CNT);
  assign push     = iPlot && oReady && in_range;
  assign drop     = iPlot && !(oReady && in_range);
  // Gated by reset so a reset mid-transfer cannot complete a write
  assign oWe      = iResetn && (cnt_q != '0);
  assign pop      = oWe && iMemReady;
  assign addr_in  = 15'(iY) * FBW + 15'(iX);
  assign oAddr    = oWe ? addr_mem[rd_q] : '0;
  assign oData    = oWe ? col_mem[rd_q]  : '0;

  assign oFrameValid = (state_q == REPORT);
  assign oPixCount   = stat_pix_q;
  assign oDropCount  = stat_drop_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (iFrameDone) state_d = FLUSH;
      FLUSH:   if (cnt_q == '0) state_d = REPORT;
      REPORT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    // Counters restart in REPORT; activity there belongs to the next frame
    pix_d  = (state_q == REPORT) ? '0 : pix_q;
    drop_d = (state_q == REPORT) ? '0 : drop_q;
    if (pop && pix_d != '1)   pix_d  = pix_d + 1'b1;
    if (drop && drop_d != '1) drop_d = drop_d + 1'b1;
  end

  always_ff @(posedge iClock) begin
    if (push) begin
      addr_mem[wr_q] <= addr_in;
      col_mem[wr_q]  <= iColour;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state_q     <= RUN;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      pix_q       <= '0;
      drop_q      <= '0;
      stat_pix_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      drop_q  <= drop_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (state_d == REPORT && state_q != REPORT) begin
        stat_pix_q  <= pix_q;
        stat_drop_q <= drop_q;
      end
    end
  end

`ifdef PLOT_CAPTURE_BBOX_EN
  logic [7:0] minx_q, maxx_q, minx_d, maxx_d, ominx_q, omaxx_q;
  logic [6:0] miny_q, maxy_q, miny_d, maxy_d, ominy_q, omaxy_q;

  always_comb begin
    minx_d = (state_q == REPORT) ? '1 : minx_q;
    maxx_d = (state_q == REPORT) ? '0 : maxx_q;
    miny_d = (state_q == REPORT) ? '1 : miny_q;
    maxy_d = (state_q == REPORT) ? '0 : maxy_q;
    if (push) begin
      if (iX < minx_d) minx_d = iX;
      if (iX > maxx_d) maxx_d = iX;
      if (iY < miny_d) miny_d = iY;
      if (iY > maxy_d) maxy_d = iY;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      minx_q  <= '1;
      maxx_q  <= '0;
      miny_q  <= '1;
      maxy_q  <= '0;
      ominx_q <= '1;
      omaxx_q <= '0;
      ominy_q <= '1;
      omaxy_q <= '0;
    end else begin
      minx_q <= minx_d;
      maxx_q <= maxx_d;
      miny_q <= miny_d;
      maxy_q <= maxy_d;
      if (state_d == REPORT && state_q != REPORT) begin
        ominx_q <= minx_q;
        omaxx_q <= maxx_q;
        ominy_q <= miny_q;
        omaxy_q <= maxy_q;
      end
    end
  end

  assign oMinX = ominx_q;
  assign oMaxX = omaxx_q;
  assign oMinY = ominy_q;
  assign oMaxY = omaxy_q;
`else
  assign oMinX = '0;
  assign oMaxX = '0;
  assign oMinY = '0;
  assign oMaxY = '0;
`endif

endmodule

// File: tb/tb_plot_capture.sv
// Bench for plot_capture: vector table of single pixels, a write scoreboard, and frame/stall/reset sequences.
module tb_plot_capture;
  logic        iClock = 1'b0;
  logic        iResetn = 1'b0;
  logic [7:0]  iX = '0;
  logic [6:0]  iY = '0;
  logic [5:0]  iColour = '0;
  logic        iPlot = 1'b0;
  logic        iFrameDone = 1'b0;
  logic        iMemReady = 1'b1;
  logic        oReady, oWe, oFrameValid;
  logic [14:0] oAddr;
  logic [5:0]  oData;
  logic [15:0] oPixCount;
  logic [7:0]  oDropCount, oMinX, oMaxX;
  logic [6:0]  oMinY, oMaxY;

  int tests = 0;
  int fails = 0;
  logic [20:0] sb_q[$];

  plot_capture #(.FIFO_DEPTH(8), .X_MAX(159), .Y_MAX(119), .FB_WIDTH(160)) dut (
    .iClock(iClock), .iResetn(iResetn), .iX(iX), .iY(iY), .iColour(iColour),
    .iPlot(iPlot), .iFrameDone(iFrameDone), .oReady(oReady), .oAddr(oAddr),
    .oData(oData), .oWe(oWe), .iMemReady(iMemReady), .oFrameValid(oFrameValid),
    .oPixCount(oPixCount), .oDropCount(oDropCount), .oMinX(oMinX), .oMaxX(oMaxX),
    .oMinY(oMinY), .oMaxY(oMaxY)
  );

  always #5 iClock = ~iClock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every completed write must match the oldest expected pixel
  always @(negedge iClock) begin
    if (iResetn && oWe && iMemReady) begin
      if (sb_q.size() == 0) check("sb_unexpected_write", 32'(oAddr), 32'hFFFF_FFFF);
      else check("sb_write", 32'({oAddr, oData}), 32'(sb_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Drive one pixel for one cycle; exp_rdy is the oReady level the bench expects
  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [5:0] c,
                      input bit exp_rdy, input bit fd);
    bit acc;
    int a;
    iX = x; iY = y; iColour = c; iPlot = 1'b1; iFrameDone = fd;
    #1;
    check("ready", 32'(oReady), 32'(exp_rdy));
    acc = exp_rdy && (x <= 8'd159) && (y <= 7'd119);
    a = int'(y) * 160 + int'(x);
    if (acc) sb_q.push_back({15'(a), c});
    step();
    iPlot = 1'b0; iFrameDone = 1'b0;
  endtask

  task automatic frame_done();
    iFrameDone = 1'b1;
    step();
    iFrameDone = 1'b0;
  endtask

  task automatic wait_report(input logic [15:0] pix, input logic [7:0] drop,
                             input logic [7:0] minx, input logic [7:0] maxx,
                             input logic [6:0] miny, input logic [6:0] maxy);
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (oFrameValid) begin
        seen = 1;
        break;
      end
      step();
    end
    check("report_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("pix_count", 32'(oPixCount), 32'(pix));
      check("drop_count", 32'(oDropCount), 32'(drop));
`ifdef PLOT_CAPTURE_BBOX_EN
      check("min_x", 32'(oMinX), 32'(minx));
      check("max_x", 32'(oMaxX), 32'(maxx));
      check("min_y", 32'(oMinY), 32'(miny));
      check("max_y", 32'(oMaxY), 32'(maxy));
`else
      check("bbox_off", 32'({oMinX, oMaxX, oMinY, oMaxY}), 32'd0);
      check("bbox_args", 32'({minx, maxx, miny, maxy}) & 32'd0, 32'd0);
`endif
    end
  endtask

  task automatic check_bbox_reset();
`ifdef PLOT_CAPTURE_BBOX_EN
    check("rst_bbox", 32'({oMinX, oMaxX, oMinY, oMaxY}), 32'({8'hFF, 8'h00, 7'h7F, 7'h00}));
`else
    check("rst_bbox", 32'({oMinX, oMaxX, oMinY, oMaxY}), 32'd0);
`endif
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [5:0]  c;
    bit          acc;
    logic [14:0] addr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd20,  7'd20,  6'b111110, 1'b1, 15'd3220};
    vecs[1] = '{8'd0,   7'd0,   6'h01,     1'b1, 15'd0};
    vecs[2] = '{8'd159, 7'd119, 6'h2A,     1'b1, 15'd19199};
    vecs[3] = '{8'd160, 7'd5,   6'h3F,     1'b0, 15'd0};
    vecs[4] = '{8'd3,   7'd120, 6'h15,     1'b0, 15'd0};
    vecs[5] = '{8'd255, 7'd127, 6'h0F,     1'b0, 15'd0};
    vecs[6] = '{8'd100, 7'd50,  6'h33,     1'b1, 15'd8100};

    // Reset state
    idle(3);
    check("rst_we", 32'(oWe), 32'd0);
    check("rst_addr_data", 32'({oAddr, oData}), 32'd0);
    check("rst_fv", 32'(oFrameValid), 32'd0);
    check("rst_stats", 32'({oPixCount, oDropCount}), 32'd0);
    check_bbox_reset();
    iResetn = 1'b1;
    step();
    check("rst_ready", 32'(oReady), 32'd1);

    // Single pixels into an empty FIFO: visible one cycle after acceptance, gone the next
    foreach (vecs[i]) begin
      plot(vecs[i].x, vecs[i].y, vecs[i].c, 1'b1, 1'b0);
      check("vec_we", 32'(oWe), 32'(vecs[i].acc));
      if (vecs[i].acc) begin
        check("vec_addr", 32'(oAddr), 32'(vecs[i].addr));
        check("vec_data", 32'(oData), 32'(vecs[i].c));
      end
      step();
      check("vec_we_clear", 32'(oWe), 32'd0);
    end
    frame_done();
    check("flush_ready", 32'(oReady), 32'd0);
    check("flush_fv", 32'(oFrameValid), 32'd0);
    step();
    check("fv_after_1cyc_flush", 32'(oFrameValid), 32'd1);
    wait_report(16'd4, 8'd3, 8'd0, 8'd159, 7'd0, 7'd119);
    step();
    check("fv_pulse", 32'(oFrameValid), 32'd0);
    check("stats_hold", 32'(oPixCount), 32'd4);

    // Out-of-range only frame
    plot(8'd160, 7'd5, 6'h11, 1'b1, 1'b0);
    plot(8'd3, 7'd120, 6'h12, 1'b1, 1'b0);
    check("oor_no_we", 32'(oWe), 32'd0);
    frame_done();
    wait_report(16'd0, 8'd2, 8'hFF, 8'd0, 7'h7F, 7'd0);
    // A pixel in REPORT is dropped and charged to the next frame
    plot(8'd5, 7'd5, 6'h01, 1'b0, 1'b0);

    // Backpressure: 8 accepts, 2 drops; a full FIFO refuses even while popping; FLUSH drops
    iMemReady = 1'b0;
    for (int i = 0; i < 10; i++) plot(8'(i), 7'd1, 6'(i), i < 8, 1'b0);
    iMemReady = 1'b1;
    plot(8'd50, 7'd1, 6'h3F, 1'b0, 1'b0);
    frame_done();
    plot(8'd60, 7'd1, 6'h3E, 1'b0, 1'b0);
    wait_report(16'd8, 8'd5, 8'd0, 8'd7, 7'd1, 7'd1);
    step();

    // Stall with head at address 1000
    iMemReady = 1'b0;
    plot(8'd40, 7'd6, 6'h15, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_we", 32'(oWe), 32'd1);
      check("stall_addr", 32'(oAddr), 32'd1000);
      check("stall_data", 32'(oData), 32'h15);
      step();
    end
    iMemReady = 1'b1;
    step();
    check("stall_popped", 32'(oWe), 32'd0);
    frame_done();
    wait_report(16'd1, 8'd0, 8'd40, 8'd40, 7'd6, 7'd6);
    step();

    // 12x10 box at (20,20); last pixel coincides with iFrameDone and still counts
    for (int yy = 0; yy < 10; yy++)
      for (int xx = 0; xx < 12; xx++)
        plot(8'(20 + xx), 7'(20 + yy), 6'(xx + yy), 1'b1, (yy == 9) && (xx == 11));
    wait_report(16'd120, 8'd0, 8'd20, 8'd31, 7'd20, 7'd29);
    step();

    // Reset with 4 entries queued
    iMemReady = 1'b0;
    for (int i = 0; i < 4; i++) plot(8'(70 + i), 7'd9, 6'(i), 1'b1, 1'b0);
    check("pre_rst_we", 32'(oWe), 32'd1);
    iResetn = 1'b0;
    step();
    sb_q.delete();
    check("mid_rst_we", 32'(oWe), 32'd0);
    check("mid_rst_ready", 32'(oReady), 32'd1);
    check("mid_rst_stats", 32'({oPixCount, oDropCount}), 32'd0);
    check("mid_rst_fv", 32'(oFrameValid), 32'd0);
    check_bbox_reset();
    iResetn = 1'b1;
    iMemReady = 1'b1;
    step();
    check("post_rst_we", 32'(oWe), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/plot_capture.md
Name: plot_capture

Overview:
- Receiving end of the pixel-plot stream that the character and maze drawers emit (X, Y, 6-bit colour, plot strobe).
- Validates each plotted pixel, buffers it in a small FIFO and drains it to the framebuffer RAM write port with a ready handshake.
- At each frame boundary, reports per-frame statistics so the game FSM can tell that a redraw landed fully on screen.

Parameters:
- FIFO_DEPTH, 8, entries in the pixel FIFO; must be a power of 2, minimum 2.
- X_MAX, 159, largest legal X coordinate.
- Y_MAX, 119, largest legal Y coordinate.
- FB_WIDTH, 160, framebuffer row pitch in pixels.

Ports:
- iClock  in  1  clock
- iResetn  in  1  synchronous active-low reset
- iX  in  8  pixel X from the drawer
- iY  in  7  pixel Y from the drawer
- iColour  in  6  pixel colour, RRGGBB
- iPlot  in  1  pixel valid strobe, one pixel per cycle
- iFrameDone  in  1  one-cycle pulse: drawer finished the current frame
- oReady  out  1  pixel would be accepted this cycle
- oAddr  out  15  framebuffer write address
- oData  out  6  framebuffer write colour
- oWe  out  1  write request (valid)
- iMemReady  in  1  RAM accepts the write this cycle
- oFrameValid  out  1  one-cycle pulse: frame stats updated
- oPixCount  out  16  pixels written to RAM in the last frame
- oDropCount  out  8  pixels dropped in the last frame
- oMinX/oMaxX  out  8  bounding box X (optional feature)
- oMinY/oMaxY  out  7  bounding box Y (optional feature)

Behaviour:
- Reset (iResetn=0 at posedge), all outputs:
  - FIFO empty, state RUN, internal counters 0.
  - oWe=0, oAddr=0, oData=0, oFrameValid=0, oPixCount=0, oDropCount=0.
  - oMinX=8'hFF, oMinY=7'h7F, oMaxX=0, oMaxY=0.
  - Reset mid-transfer discards all FIFO contents; no write completes that cycle.
- Accept rule:
  - A pixel is accepted when iPlot=1, oReady=1, iX<=X_MAX and iY<=Y_MAX.
  - oReady = (state==RUN) && (fifo count < FIFO_DEPTH).
  - A push is rejected when the FIFO is full, even if a pop occurs the same cycle.
- Drop rule: iPlot=1 with oReady=0, or with an out-of-range coordinate, increments the frame drop counter.
  - Drop counter saturates at 255.
  - A pixel that is both out of range and arrives while not ready counts once.
- Address:
  - Computed at enqueue as iY*FB_WIDTH + iX, 15 bits. Max legal value 19199.
  - Stored in the FIFO alongside the colour.
- Write side:
  - oWe=1 whenever the FIFO is non-empty; oAddr/oData show the head entry.
  - The entry pops on the cycle with oWe && iMemReady.
  - oAddr/oData hold stable while oWe=1 and iMemReady=0.
- Latency:
  - A pixel accepted at edge N into an empty FIFO shows oWe=1 after edge N.
  - It is therefore visible to the RAM on cycle N+1.
  - Sustained throughput is 1 pixel/cycle when iMemReady=1 continuously.
  - Simultaneous push and pop when not full: count unchanged, order preserved (FIFO).
- Frame counters:
  - pixCnt increments on each completed write, saturating at 16'hFFFF.
  - dropCnt as above.
- FSM:
  - RUN: normal operation. iFrameDone=1 -> FLUSH.
  - FLUSH:
    - oReady=0, so incoming pixels are dropped and counted.
    - Writes continue draining.
    - FIFO empty -> REPORT. If already empty on entry, FLUSH lasts exactly 1 cycle.
  - REPORT (1 cycle):
    - oFrameValid=1.
    - oPixCount<=pixCnt and oDropCount<=dropCnt, visible in the same cycle as oFrameValid (registered on the REPORT entry edge).
    - Internal counters clear. iPlot in REPORT is dropped and counted in the next frame.
    - Next state is RUN.
  - iFrameDone in FLUSH/REPORT is ignored.
  - iFrameDone coincident with iPlot in RUN: that pixel is accepted in the current frame.
- Latched stats hold until the next REPORT.

Optional Feature:
- Macro: PLOT_CAPTURE_BBOX_EN.
- Defined:
  - Tracks min/max X and Y over accepted pixels of the current frame.
  - Latched onto oMinX/oMaxX/oMinY/oMaxY in REPORT alongside oPixCount; the trackers reset to FF/7F/0/0 there.
  - A frame with zero accepted pixels reports FF/0/7F/0.
- Undefined: no tracking logic; the four outputs are constant 0.

Test Plan:
- Reset, then single pixel (X=20, Y=20, C=6'b111110), iMemReady=1 -> next cycle oWe=1, oAddr=3220, oData=6'b111110; one cycle later oWe=0.
- iMemReady=0, 10 consecutive plots -> oReady falls after 8 accepts, 2 drops; iMemReady=1 and iFrameDone -> 8 writes in order, then oFrameValid with oPixCount=8, oDropCount=2.
- Plot X=160, Y=5 and X=3, Y=120 -> no writes; next frame report oDropCount=2, oPixCount=0, bbox FF/0/7F/0.
- Stall iMemReady=0 for 5 cycles with head entry addr 1000 -> oAddr=1000 and oData unchanged throughout, pops on first ready cycle.
- Draw a 12x10 box at (20,20), iMemReady=1, iFrameDone -> oPixCount=120; with BBOX_EN: min (20,20), max (31,29).
- Assert iResetn=0 with 4 entries queued -> next cycle oWe=0, oReady=1, stats 0.
